// File: rtl/mc_control_unit_pkg.sv
// Shared encodings for the multicycle control unit: opcodes, ALU operations,
// branch types, next-PC selects, operand selects and FSM state numbering.
package mc_control_unit_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_XOR = 4'b1001;
  localparam logic [3:0] ALU_SLL = 4'b1010;
  localparam logic [3:0] ALU_SRL = 4'b1100;

  localparam logic [1:0] BT_BEQ = 2'b00;
  localparam logic [1:0] BT_BNE = 2'b01;
  localparam logic [1:0] BT_BLT = 2'b10;
  localparam logic [1:0] BT_BGE = 2'b11;

  localparam logic [1:0] PCS_PLUS4 = 2'b00;
  localparam logic [1:0] PCS_ALU   = 2'b01;
  localparam logic [1:0] PCS_JALR  = 2'b10;

  localparam logic       SRCA_PC   = 1'b0;
  localparam logic       SRCA_RS1  = 1'b1;
  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;

  typedef enum logic [2:0] {
    ST_IF   = 3'd0,
    ST_ID   = 3'd1,
    ST_EX   = 3'd2,
    ST_MEM  = 3'd3,
    ST_WB   = 3'd4,
    ST_HALT = 3'd5
  } state_e;

endpackage

// File: rtl/alu_op_decode.sv
// Combinational decode of opcode/funct3/funct7[5] into the ALU operation and
// branch type used by the control unit in EX.
module alu_op_decode
  import mc_control_unit_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7_b5,
  output logic [3:0] alu_op,
  output logic [1:0] btype
);

  // Opcode/funct decode to ALU op and branch type.
  always_comb begin
    alu_op = ALU_ADD;
    btype  = BT_BEQ;
    case (opcode)
      OP_R, OP_IMM: begin
        case (funct3)
          3'b000: begin
            // SUB only exists for R-type; I-arith funct3 000 is always ADD.
            if ((opcode == OP_R) && funct7_b5) begin
              alu_op = ALU_SUB;
            end else begin
              alu_op = ALU_ADD;
            end
          end
          3'b111:  alu_op = ALU_AND;
          3'b110:  alu_op = ALU_OR;
          3'b100:  alu_op = ALU_XOR;
          3'b001:  alu_op = ALU_SLL;
          3'b101:  alu_op = ALU_SRL;
          default: alu_op = ALU_ADD;
        endcase
      end
      OP_BRANCH: begin
        alu_op = ALU_SUB;
        case (funct3)
          3'b000:  btype = BT_BEQ;
          3'b001:  btype = BT_BNE;
          3'b100:  btype = BT_BLT;
          3'b101:  btype = BT_BGE;
          default: btype = BT_BEQ;
        endcase
      end
      default: begin
        alu_op = ALU_ADD;
        btype  = BT_BEQ;
      end
    endcase
  end

endmodule

// File: rtl/mc_control_unit.sv
// Multicycle RV32 control FSM (IF/ID/EX/MEM/WB/HALT); outputs decode from state,
// instr and the handshake inputs. Define ECALL_HALT_EN to enable ECALL halting.
module mc_control_unit
  import mc_control_unit_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr,
  input  logic        mem_ready,
  input  logic        alu_bcond,
  input  logic        is_halt_reg,
  output logic [3:0]  alu_op,
  output logic [1:0]  btype,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic        pc_write,
  output logic        i_or_d,
  output logic        mem_read,
  output logic        mem_write,
  output logic        ir_write,
  output logic        reg_write,
  output logic        mem_to_reg,
  output logic [1:0]  pc_src,
  output logic        is_halted,
  output logic [2:0]  state_out
);

  state_e     state_q;
  state_e     state_d;
  logic [6:0] opcode_s;
  logic [3:0] dec_alu_op_s;
  logic [1:0] dec_btype_s;
  logic       op_r_s;
  logic       op_imm_s;
  logic       op_load_s;
  logic       op_store_s;
  logic       op_branch_s;
  logic       op_jal_s;
  logic       op_jalr_s;
  logic       op_exec_s;
  logic       halt_req_s;
  logic       unused_bits_s;

  assign opcode_s    = instr[6:0];
  assign op_r_s      = (opcode_s == OP_R);
  assign op_imm_s    = (opcode_s == OP_IMM);
  assign op_load_s   = (opcode_s == OP_LOAD);
  assign op_store_s  = (opcode_s == OP_STORE);
  assign op_branch_s = (opcode_s == OP_BRANCH);
  assign op_jal_s    = (opcode_s == OP_JAL);
  assign op_jalr_s   = (opcode_s == OP_JALR);
  assign op_exec_s   = op_r_s | op_imm_s | op_load_s | op_store_s |
                       op_branch_s | op_jal_s | op_jalr_s;

`ifdef ECALL_HALT_EN
  assign halt_req_s    = (opcode_s == OP_SYSTEM) & is_halt_reg;
  assign unused_bits_s = ^{instr[31], instr[29:15], instr[11:7]};
`else
  assign halt_req_s    = 1'b0;
  assign unused_bits_s = ^{instr[31], instr[29:15], instr[11:7], is_halt_reg};
`endif

  alu_op_decode u_alu_op_decode (
    .opcode    (opcode_s),
    .funct3    (instr[14:12]),
    .funct7_b5 (instr[30]),
    .alu_op    (dec_alu_op_s),
    .btype     (dec_btype_s)
  );

  // Next-state and per-state control outputs; everything idles low under reset.
  always_comb begin
    state_d    = state_q;
    alu_op     = ALU_AND;
    btype      = BT_BEQ;
    alu_src_a  = SRCA_PC;
    alu_src_b  = SRCB_RS2;
    pc_write   = 1'b0;
    i_or_d     = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    mem_to_reg = 1'b0;
    pc_src     = PCS_PLUS4;
    is_halted  = 1'b0;
    if (reset) begin
      state_d = ST_IF;
    end else begin
      case (state_q)
        ST_IF: begin
          mem_read = 1'b1;
          ir_write = mem_ready;
          if (mem_ready) begin
            state_d = ST_ID;
          end else begin
            state_d = ST_IF;
          end
        end
        ST_ID: begin
          if (halt_req_s) begin
            state_d = ST_HALT;
          end else if (op_exec_s) begin
            state_d = ST_EX;
          end else begin
            // Unknown opcodes and non-halting ECALLs retire here as a NOP.
            pc_write = 1'b1;
            pc_src   = PCS_PLUS4;
            state_d  = ST_IF;
          end
        end
        ST_EX: begin
          alu_op    = dec_alu_op_s;
          btype     = dec_btype_s;
          alu_src_a = op_jal_s ? SRCA_PC : SRCA_RS1;
          alu_src_b = (op_r_s | op_branch_s) ? SRCB_RS2 : SRCB_IMM;
          if (op_branch_s) begin
            pc_write = 1'b1;
            pc_src   = alu_bcond ? PCS_ALU : PCS_PLUS4;
            state_d  = ST_IF;
          end else if (op_load_s | op_store_s) begin
            state_d = ST_MEM;
          end else begin
            state_d = ST_WB;
          end
        end
        ST_MEM: begin
          i_or_d    = 1'b1;
          mem_read  = op_load_s;
          mem_write = op_store_s;
          if (!mem_ready) begin
            state_d = ST_MEM;
          end else if (op_store_s) begin
            pc_write = 1'b1;
            pc_src   = PCS_PLUS4;
            state_d  = ST_IF;
          end else begin
            state_d = ST_WB;
          end
        end
        ST_WB: begin
          reg_write  = 1'b1;
          mem_to_reg = op_load_s;
          pc_write   = 1'b1;
          if (op_jal_s) begin
            pc_src = PCS_ALU;
          end else if (op_jalr_s) begin
            pc_src = PCS_JALR;
          end else begin
            pc_src = PCS_PLUS4;
          end
          state_d = ST_IF;
        end
        ST_HALT: begin
`ifdef ECALL_HALT_EN
          is_halted = 1'b1;
          state_d   = ST_HALT;
`else
          state_d   = ST_IF;
`endif
        end
        default: begin
          state_d = ST_IF;
        end
      endcase
    end
  end

  // State register with synchronous reset to IF.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IF;
    end else begin
      state_q <= state_d;
    end
  end

  assign state_out = state_q;

endmodule

// File: tb/tb_mc_control_unit.sv
// Randomized bench for mc_control_unit against an instruction-level phase model.
// Covers both builds; HALT expectations follow ECALL_HALT_EN.
module tb_mc_control_unit;

  localparam int P_IF = 0, P_ID = 1, P_EX = 2, P_MEM = 3, P_WB = 4, P_HALT = 5;
  localparam int K_ILL = 0, K_R = 1, K_IMM = 2, K_LOAD = 3, K_STORE = 4,
                 K_BR = 5, K_JAL = 6, K_JALR = 7, K_ECALL = 8;
`ifdef ECALL_HALT_EN
  localparam bit HALT_EN = 1'b1;
`else
  localparam bit HALT_EN = 1'b0;
`endif

  typedef struct packed {
    logic       pc_write;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic       mem_to_reg;
    logic       is_halted;
    logic [1:0] pc_src;
    logic [3:0] alu_op;
    logic [1:0] btype;
  } outs_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instr;
  logic        mem_ready;
  logic        alu_bcond;
  logic        is_halt_reg;
  logic [3:0]  alu_op;
  logic [1:0]  btype;
  logic        alu_src_a;
  logic [1:0]  alu_src_b;
  logic        pc_write, i_or_d, mem_read, mem_write, ir_write, reg_write, mem_to_reg;
  logic [1:0]  pc_src;
  logic        is_halted;
  logic [2:0]  state_out;

  int vectors     = 0;
  int miscompares = 0;
  int pcw_seen    = 0;
  int bc_mode     = -1;

  mc_control_unit dut (
    .clk(clk), .reset(reset), .instr(instr), .mem_ready(mem_ready),
    .alu_bcond(alu_bcond), .is_halt_reg(is_halt_reg),
    .alu_op(alu_op), .btype(btype), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .pc_write(pc_write), .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write),
    .ir_write(ir_write), .reg_write(reg_write), .mem_to_reg(mem_to_reg),
    .pc_src(pc_src), .is_halted(is_halted), .state_out(state_out)
  );

  always #5 clk = ~clk;

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic rb();
    return $urandom_range(0, 1) == 1;
  endfunction

  function automatic int kind_of(input logic [6:0] op);
    case (op)
      7'b0110011: return K_R;
      7'b0010011: return K_IMM;
      7'b0000011: return K_LOAD;
      7'b0100011: return K_STORE;
      7'b1100011: return K_BR;
      7'b1101111: return K_JAL;
      7'b1100111: return K_JALR;
      7'b1110011: return K_ECALL;
      default:    return K_ILL;
    endcase
  endfunction

  function automatic bit goes_to_ex(input int k);
    return (k >= K_R) && (k <= K_JALR);
  endfunction

  function automatic logic [3:0] ref_alu_op(input logic [31:0] ins);
    int k;
    k = kind_of(ins[6:0]);
    if (k == K_BR) return 4'b0110;
    if (k == K_R || k == K_IMM) begin
      case (ins[14:12])
        3'b000:  return (k == K_R && ins[30]) ? 4'b0110 : 4'b0010;
        3'b111:  return 4'b0000;
        3'b110:  return 4'b0001;
        3'b100:  return 4'b1001;
        3'b001:  return 4'b1010;
        3'b101:  return 4'b1100;
        default: return 4'b0010;
      endcase
    end
    return 4'b0010;
  endfunction

  function automatic logic [1:0] ref_btype(input logic [31:0] ins);
    if (kind_of(ins[6:0]) != K_BR) return 2'b00;
    case (ins[14:12])
      3'b001:  return 2'b01;
      3'b100:  return 2'b10;
      3'b101:  return 2'b11;
      default: return 2'b00;
    endcase
  endfunction

  function automatic outs_t exp_outs(input int p, input logic [31:0] ins, input logic mr,
                                     input logic bc, input logic hr);
    outs_t o;
    int    k;
    o = '0;
    k = kind_of(ins[6:0]);
    case (p)
      P_IF: begin
        o.mem_read = 1'b1;
        o.ir_write = mr;
      end
      P_ID: begin
        if (!goes_to_ex(k) && !(HALT_EN && k == K_ECALL && hr)) o.pc_write = 1'b1;
      end
      P_EX: begin
        o.alu_op = ref_alu_op(ins);
        o.btype  = ref_btype(ins);
        if (k == K_BR) begin
          o.pc_write = 1'b1;
          o.pc_src   = bc ? 2'b01 : 2'b00;
        end
      end
      P_MEM: begin
        o.i_or_d    = 1'b1;
        o.mem_read  = (k == K_LOAD);
        o.mem_write = (k == K_STORE);
        o.pc_write  = (k == K_STORE) && mr;
      end
      P_WB: begin
        o.reg_write  = 1'b1;
        o.mem_to_reg = (k == K_LOAD);
        o.pc_write   = 1'b1;
        o.pc_src     = (k == K_JAL) ? 2'b01 : (k == K_JALR) ? 2'b10 : 2'b00;
      end
      P_HALT: o.is_halted = 1'b1;
      default: o = '0;
    endcase
    return o;
  endfunction

  function automatic outs_t pack_outs();
    return {pc_write, i_or_d, mem_read, mem_write, ir_write, reg_write, mem_to_reg,
            is_halted, pc_src, alu_op, btype};
  endfunction

  // One cycle in expected phase p: drive, check at negedge, advance past posedge.
  task automatic step_check(input int p, input logic mr);
    mem_ready = mr;
    alu_bcond = (bc_mode < 0) ? rb() : bc_mode[0];
    @(negedge clk);
    check_value("state", {29'd0, state_out}, p);
    check_value($sformatf("outs_p%0d", p), {16'd0, pack_outs()},
                {16'd0, exp_outs(p, instr, mr, alu_bcond, is_halt_reg)});
    if (pc_write) pcw_seen++;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset     = 1'b1;
    mem_ready = rb();
    @(negedge clk);
    check_value("rst_outs", {16'd0, pack_outs()}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic run_instr(input logic [31:0] ins, input int if_wait, input int mem_wait,
                           input logic hr);
    int k;
    instr       = ins;
    is_halt_reg = hr;
    pcw_seen    = 0;
    k           = kind_of(ins[6:0]);
    for (int w = 0; w <= if_wait; w++) step_check(P_IF, w == if_wait);
    step_check(P_ID, rb());
    if (HALT_EN && k == K_ECALL && hr) begin
      repeat (10) step_check(P_HALT, rb());
      check_value("halt_pcw", pcw_seen, 0);
      apply_reset();
      return;
    end
    if (goes_to_ex(k)) begin
      step_check(P_EX, rb());
      if (k == K_LOAD || k == K_STORE) begin
        for (int w = 0; w <= mem_wait; w++) step_check(P_MEM, w == mem_wait);
      end
      if (k != K_STORE && k != K_BR) step_check(P_WB, rb());
    end
    check_value("pcw_count", pcw_seen, 1);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    logic [2:0]  bf [4];
    logic [6:0]  ill [5];
    bf  = '{3'b000, 3'b001, 3'b100, 3'b101};
    ill = '{7'h00, 7'h37, 7'h17, 7'h0F, 7'h7F};
    r   = $urandom;
    case ($urandom_range(0, 9))
      0:       r[6:0] = 7'b0110011;
      1:       r[6:0] = 7'b0010011;
      2:       r[6:0] = 7'b0000011;
      3:       r[6:0] = 7'b0100011;
      4: begin
        r[6:0]   = 7'b1100011;
        r[14:12] = bf[$urandom_range(0, 3)];
      end
      5:       r[6:0] = 7'b1101111;
      6:       r[6:0] = 7'b1100111;
      7:       r[6:0] = 7'b1110011;
      default: r[6:0] = ill[$urandom_range(0, 4)];
    endcase
    return r;
  endfunction

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset       = 1'b1;
    instr       = 32'd0;
    mem_ready   = 1'b0;
    alu_bcond   = 1'b0;
    is_halt_reg = 1'b0;
    @(posedge clk);
    #1;
    apply_reset();

    run_instr(32'h002081B3, 0, 0, 1'b0);   // ADD
    bc_mode = 1;
    run_instr(32'h00208463, 0, 0, 1'b0);   // BEQ taken
    bc_mode = 0;
    run_instr(32'h00208463, 0, 0, 1'b0);   // BEQ not taken
    bc_mode = -1;
    run_instr(32'h0000A103, 0, 2, 1'b0);   // LW with two wait cycles
    run_instr(32'h00000000, 0, 0, 1'b0);   // unrecognised opcode
    run_instr(32'h00000073, 0, 0, 1'b1);   // ECALL, halt register set
    run_instr(32'h00000073, 1, 0, 1'b0);   // ECALL as NOP

    // Reset in the middle of a STORE memory wait.
    instr       = 32'h0020A023;
    is_halt_reg = 1'b0;
    pcw_seen    = 0;
    step_check(P_IF, 1'b1);
    step_check(P_ID, rb());
    step_check(P_EX, rb());
    step_check(P_MEM, 1'b0);
    reset     = 1'b1;
    mem_ready = 1'b0;
    @(negedge clk);
    check_value("rst_mem_state", {29'd0, state_out}, P_MEM);
    check_value("rst_mem_outs", {16'd0, pack_outs()}, 32'd0);
    if (pc_write) pcw_seen++;
    @(posedge clk);
    #1;
    reset = 1'b0;
    step_check(P_IF, 1'b0);
    check_value("rst_store_pcw", pcw_seen, 0);

    for (int n = 0; n < 300; n++) begin
      run_instr(rand_instr(), $urandom_range(0, 3), $urandom_range(0, 3), rb());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
